spi_flash_slave_shifter: RTL and testbench
==========================================

// Module: spi_flash_slave_shifter
// PURPOSE
//  SPI target-side character engine, mode 0 (CPOL=0, CPHA=0), MSB first. Sits on the flash-emulation
//  side of the SPI link, opposite the master clock generator. Oversamples external sclk/ss_n/mosi on
//  clk_in, detects sclk edges, deserialises mosi into rx_data, and serialises a buffered tx_data onto miso.
// PARAMETERS
//  char_len     8   bits per character; also width of rx_data/tx_data and of the shift registers
//  cnt_len      3   bit counter width; must satisfy 2**cnt_len >= char_len
//  sync_stages  2   flops per input synchroniser, minimum 2
//  Tp           1   non-blocking assignment delay, as in the other spi_flash_* blocks
// PORTS
//  clk_in     in   1         system clock; must run >= 4x sclk
//  rst        in   1         asynchronous, active-high reset
//  sclk       in   1         external SPI clock (asynchronous to clk_in)
//  ss_n       in   1         external select, active low (asynchronous)
//  mosi       in   1         external serial data in (asynchronous)
//  miso       out  1         serial data out, valid while selected
//  miso_oe    out  1         1 = drive miso pad; 0 = tristate
//  tx_data    in   char_len  next character to transmit
//  tx_load    in   1         write tx_data into tx buffer; honoured only when tx_ready=1
//  tx_ready   out  1         tx buffer empty
//  rx_data    out  char_len  last complete received character; holds until next one
//  rx_valid   out  1         one-cycle pulse: rx_data updated this cycle
//  tx_underrun out 1         one-cycle pulse: shift reload found tx buffer empty, 1s sent instead
//  busy       out  1         synchronised select active
// BEHAVIOUR
//  Reset: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0; counters 0;
//   synchronisers reset to sclk=0, ss_n=1, mosi=0.
//  Sync: each input passes sync_stages flops; edge detect compares last stage with a registered copy.
//   Internal edge pulses (sclk_rise, sclk_fall, sel_start, sel_end) are 1 clk_in wide.
//  States: IDLE (ss_n high) / ACTIVE. IDLE->ACTIVE on sel_start; ACTIVE->IDLE on sel_end.
//  sel_start: bit_cnt=0; tx shift reg <- tx buffer (tx_ready->1) or all-ones + tx_underrun pulse
//   if empty; miso_oe=1 and miso=shift MSB in the same cycle; busy=1.
//  sclk_rise (ACTIVE): rx shift <= {rx shift[char_len-2:0], mosi_sync}; bit_cnt++. When bit_cnt was
//   char_len-1: rx_data <= completed char, rx_valid pulses next cycle (latency from pin edge:
//   sync_stages+2 clk_in, +1 sampling uncertainty), bit_cnt wraps to 0, reload_pend set.
//  sclk_fall (ACTIVE): if reload_pend, reload tx shift (same rule as sel_start), clear reload_pend;
//   else shift tx left by 1, fill 1. miso always = tx shift MSB.
//  tx buffer: single entry. tx_load && tx_ready -> capture, tx_ready=0; tx_load && !tx_ready ignored.
//   tx_load in the same cycle as a reload: loaded value is used, tx_ready stays 1.
//  sel_end mid-character: partial bits discarded, no rx_valid, bit_cnt=0, reload_pend=0, miso_oe=0,
//   tx buffer contents kept. Simultaneous sclk edge and sel_end: sel_end wins, edge ignored.
//  sclk edges while IDLE are ignored. rx_data is overwritten without handshake; consumer must take it on rx_valid.
//  rst mid-transfer: all state to reset values immediately; new transfer needs fresh ss_n fall.
// STRUCTURE
//  `defines in spi_defines.v: SPI_SLV_IDLE/SPI_SLV_ACTIVE state encodings, default char_len.
//  One sub-module: spi_flash_sync (parameterised N-stage synchroniser, reset value parameter),
//   instantiated for sclk, ss_n, mosi. Edge detect, FSM, counters, shifters stay in this module.
// TESTING
//  Reset then idle: all outputs at reset values; sclk toggling with ss_n=1 -> no rx_valid, miso_oe=0.
//  tx_load 8'hA5, drop ss_n, 8 sclk at clk_in/8, mosi=8'h3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C, one rx_valid.
//  Back-to-back: bytes 8'h01,8'h80 with tx reloaded between -> two rx_valid pulses, miso reloads after 8th rise.
//  No tx_load before ss_n fall -> tx_underrun pulse, miso=1 for all 8 bits; rx still correct.
//  ss_n rises after 5 sclk -> no rx_valid, miso_oe=0; next transfer of 8'hFF received intact.
//  rst asserted mid-byte -> outputs at reset values next clk_in; tx_load while tx_ready=0 ignored.

Source files
------------

// File: rtl/spi_flash_slave_shifter_pkg.sv
// Shared types and defaults for the SPI flash-emulation target shifter.
// Holds the select FSM encoding and the default character length.
package spi_flash_slave_shifter_pkg;

  localparam int CHAR_LEN_DEF = 8;

  typedef enum logic {
    SPI_SLV_IDLE   = 1'b0,
    SPI_SLV_ACTIVE = 1'b1
  } slv_state_e;

endpackage

// File: rtl/spi_flash_slave_shifter_if.sv
// Character-side interface of the SPI target shifter: the tx buffer write port,
// the received-character port and the status pulses.
interface spi_flash_slave_shifter_if
  import spi_flash_slave_shifter_pkg::*;
#(
  parameter int char_len = CHAR_LEN_DEF
);

  logic [char_len-1:0] tx_data;
  logic                tx_load;
  logic                tx_ready;
  logic [char_len-1:0] rx_data;
  logic                rx_valid;
  logic                tx_underrun;
  logic                busy;

  // master = character consumer/producer, slave = the shifter itself
  modport master (
    output tx_data, tx_load,
    input  tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport slave (
    input  tx_data, tx_load,
    output tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

endinterface

// File: rtl/spi_flash_slave_shifter_sync.sv
// N-stage flop synchroniser for one asynchronous input, with a selectable
// reset level so the idle state of the pin is seen during and after reset.
module spi_flash_slave_shifter_sync #(
  parameter int   sync_stages = 2,
  parameter logic rst_val     = 1'b0
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [sync_stages-1:0] sync_p;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) sync_p <= {sync_stages{rst_val}};
    else     sync_p <= {sync_p[sync_stages-2:0], d};
  end

  assign q = sync_p[sync_stages-1];

endmodule

// File: rtl/spi_flash_slave_shifter.sv
// SPI mode-0 target character engine: oversamples sclk/ss_n/mosi on clk_in,
// deserialises mosi into rx_data and serialises a one-entry tx buffer onto miso.
module spi_flash_slave_shifter
  import spi_flash_slave_shifter_pkg::*;
#(
  parameter int char_len    = CHAR_LEN_DEF,
  parameter int cnt_len     = 3,
  parameter int sync_stages = 2
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic                      sclk,
  input  logic                      ss_n,
  input  logic                      mosi,
  output logic                      miso,
  output logic                      miso_oe,
  spi_flash_slave_shifter_if.slave  bus
);

  logic                sclk_p0, ss_n_p0, mosi_p0;
  logic                sclk_p1, ss_n_p1;
  logic                sclk_rise, sclk_fall, sel_start, sel_end;
  slv_state_e          state_q, state_d;
  logic                do_start, do_end, do_rise, do_fall, do_reload, last_bit;
  logic [cnt_len-1:0]  bit_cnt;
  logic                reload_pend;
  logic [char_len-1:0] rx_shift, rx_data_q, tx_shift, tx_buf;
  logic                rx_vld_p0, rx_valid_q, tx_ready_q, tx_underrun_q;

  spi_flash_slave_shifter_sync #(.sync_stages(sync_stages), .rst_val(1'b0)) u_sync_sclk (
    .clk_in(clk_in), .rst(rst), .d(sclk), .q(sclk_p0));
  spi_flash_slave_shifter_sync #(.sync_stages(sync_stages), .rst_val(1'b1)) u_sync_ss_n (
    .clk_in(clk_in), .rst(rst), .d(ss_n), .q(ss_n_p0));
  spi_flash_slave_shifter_sync #(.sync_stages(sync_stages), .rst_val(1'b0)) u_sync_mosi (
    .clk_in(clk_in), .rst(rst), .d(mosi), .q(mosi_p0));

  // p0 -> p1: registered copies for single-cycle edge pulses
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sclk_p1 <= 1'b0;
      ss_n_p1 <= 1'b1;
    end else begin
      sclk_p1 <= sclk_p0;
      ss_n_p1 <= ss_n_p0;
    end
  end

  assign sclk_rise = sclk_p0 & ~sclk_p1;
  assign sclk_fall = ~sclk_p0 & sclk_p1;
  assign sel_start = ~ss_n_p0 & ss_n_p1;
  assign sel_end   = ss_n_p0 & ~ss_n_p1;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state_q <= SPI_SLV_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SPI_SLV_IDLE:   if (sel_start) state_d = SPI_SLV_ACTIVE;
      SPI_SLV_ACTIVE: if (sel_end)   state_d = SPI_SLV_IDLE;
      default:        state_d = SPI_SLV_IDLE;
    endcase
  end

  // Deselect takes priority over any sclk edge seen in the same cycle.
  assign do_start  = (state_q == SPI_SLV_IDLE) && sel_start;
  assign do_end    = (state_q == SPI_SLV_ACTIVE) && sel_end;
  assign do_rise   = (state_q == SPI_SLV_ACTIVE) && sclk_rise && !sel_end;
  assign do_fall   = (state_q == SPI_SLV_ACTIVE) && sclk_fall && !sel_end;
  assign do_reload = do_start || (do_fall && reload_pend);
  assign last_bit  = (bit_cnt == cnt_len'(char_len - 1));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      tx_buf        <= '0;
      tx_shift      <= '0;
      tx_ready_q    <= 1'b1;
      tx_underrun_q <= 1'b0;
    end else begin
      tx_underrun_q <= 1'b0;
      if (do_reload) begin
        if (!tx_ready_q) begin
          tx_shift   <= tx_buf;
          tx_ready_q <= 1'b1;
        end else if (bus.tx_load) begin
          // a load landing on the reload cycle goes straight to the shifter
          tx_shift <= bus.tx_data;
        end else begin
          tx_shift      <= '1;
          tx_underrun_q <= 1'b1;
        end
      end else begin
        if (do_fall) tx_shift <= {tx_shift[char_len-2:0], 1'b1};
        if (bus.tx_load && tx_ready_q) begin
          tx_buf     <= bus.tx_data;
          tx_ready_q <= 1'b0;
        end
      end
    end
  end

  // rx stage: shift on rise; a completed char is published one cycle later
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rx_shift    <= '0;
      rx_data_q   <= '0;
      rx_vld_p0   <= 1'b0;
      rx_valid_q  <= 1'b0;
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
      miso_oe     <= 1'b0;
    end else begin
      rx_vld_p0  <= 1'b0;
      rx_valid_q <= rx_vld_p0;
      if (rx_vld_p0) rx_data_q <= rx_shift;
      if (do_start) begin
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
        miso_oe     <= 1'b1;
      end
      if (do_end) begin
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
        miso_oe     <= 1'b0;
      end
      if (do_rise) begin
        rx_shift <= {rx_shift[char_len-2:0], mosi_p0};
        if (last_bit) begin
          bit_cnt     <= '0;
          reload_pend <= 1'b1;
          rx_vld_p0   <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + cnt_len'(1);
        end
      end
      if (do_fall && reload_pend) reload_pend <= 1'b0;
    end
  end

  assign miso            = tx_shift[char_len-1];
  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.busy        = (state_q == SPI_SLV_ACTIVE);

endmodule

// File: tb/tb_spi_flash_slave_shifter.sv
// Directed bench for spi_flash_slave_shifter: acts as SPI master at clk_in/8
// and checks miso bits, received characters, pulses and status flags.
module tb_spi_flash_slave_shifter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic ss_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe;

  int checks = 0;
  int errors = 0;
  int rxv_cnt = 0;
  int und_cnt = 0;
  logic [7:0] last_rx = 8'h00;

  spi_flash_slave_shifter_if #(.char_len(8)) bus ();

  spi_flash_slave_shifter #(.char_len(8), .cnt_len(3), .sync_stages(2)) dut (
    .clk_in (clk),
    .rst    (rst),
    .sclk   (sclk),
    .ss_n   (ss_n),
    .mosi   (mosi),
    .miso   (miso),
    .miso_oe(miso_oe),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rxv_cnt = rxv_cnt + 1;
      last_rx = bus.rx_data;
    end
    if (bus.tx_underrun) und_cnt = und_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] v);
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
    @(negedge clk);
  endtask

  // Mode 0 master: present mosi, sample miso just before the rising edge.
  task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = mo[i];
      wait_clk(4);
      mi[i] = miso;
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] mi;
    int r0, u0;
    bus.tx_data = 8'h00;
    bus.tx_load = 1'b0;

    // reset state
    wait_clk(3);
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_tx_ready", bus.tx_ready, 1);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_underrun", bus.tx_underrun, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    wait_clk(4);

    // sclk toggling while deselected
    spi_bits(8'hFF, 8, mi);
    wait_clk(4);
    chk("idle_rx_cnt", rxv_cnt, 0);
    chk("idle_miso_oe", miso_oe, 0);
    chk("idle_busy", bus.busy, 0);

    // single byte: tx A5, rx 3C; trailing reload after 8th fall underruns
    u0 = und_cnt; r0 = rxv_cnt;
    load_tx(8'hA5);
    chk("a5_tx_ready_full", bus.tx_ready, 0);
    ss_n = 1'b0;
    wait_clk(4);
    chk("a5_busy", bus.busy, 1);
    chk("a5_miso_oe", miso_oe, 1);
    chk("a5_tx_ready_empty", bus.tx_ready, 1);
    chk("a5_first_miso", miso, 1);
    chk("a5_no_underrun", und_cnt - u0, 0);
    spi_bits(8'h3C, 8, mi);
    chk("a5_miso_byte", mi, 8'hA5);
    wait_clk(4);
    chk("a5_rx_cnt", rxv_cnt - r0, 1);
    chk("a5_rx_data", bus.rx_data, 8'h3C);
    chk("a5_trailing_underrun", und_cnt - u0, 1);
    ss_n = 1'b1;
    wait_clk(4);
    chk("a5_end_miso_oe", miso_oe, 0);
    chk("a5_end_busy", bus.busy, 0);
    wait_clk(4);

    // back-to-back bytes with a reload in between
    u0 = und_cnt; r0 = rxv_cnt;
    load_tx(8'hC3);
    ss_n = 1'b0;
    wait_clk(4);
    load_tx(8'h96);
    chk("b2b_tx_ready_full", bus.tx_ready, 0);
    spi_bits(8'h01, 8, mi);
    chk("b2b_miso_0", mi, 8'hC3);
    wait_clk(2);
    chk("b2b_rx_0", last_rx, 8'h01);
    spi_bits(8'h80, 8, mi);
    chk("b2b_miso_1", mi, 8'h96);
    wait_clk(4);
    chk("b2b_rx_1", last_rx, 8'h80);
    chk("b2b_rx_cnt", rxv_cnt - r0, 2);
    chk("b2b_underrun", und_cnt - u0, 1);
    ss_n = 1'b1;
    wait_clk(8);

    // no tx_load before select: underrun at start, all ones sent
    u0 = und_cnt; r0 = rxv_cnt;
    ss_n = 1'b0;
    wait_clk(4);
    chk("und_start_pulse", und_cnt - u0, 1);
    chk("und_first_miso", miso, 1);
    spi_bits(8'h69, 8, mi);
    chk("und_miso_byte", mi, 8'hFF);
    wait_clk(4);
    chk("und_rx_data", last_rx, 8'h69);
    chk("und_rx_cnt", rxv_cnt - r0, 1);
    chk("und_total", und_cnt - u0, 2);
    ss_n = 1'b1;
    wait_clk(8);

    // abort after 5 bits; buffer loaded mid-transfer survives deselect
    r0 = rxv_cnt;
    load_tx(8'h33);
    ss_n = 1'b0;
    wait_clk(4);
    load_tx(8'h4B);
    spi_bits(8'hF0, 5, mi);
    chk("abort_miso_bits", mi, 8'h30);
    ss_n = 1'b1;
    wait_clk(8);
    chk("abort_rx_cnt", rxv_cnt - r0, 0);
    chk("abort_miso_oe", miso_oe, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_tx_kept", bus.tx_ready, 0);
    u0 = und_cnt;
    ss_n = 1'b0;
    wait_clk(4);
    chk("abort_next_first_miso", miso, 0);
    chk("abort_next_no_underrun", und_cnt - u0, 0);
    spi_bits(8'hFF, 8, mi);
    chk("abort_next_miso", mi, 8'h4B);
    wait_clk(4);
    chk("abort_next_rx", last_rx, 8'hFF);
    chk("abort_next_rx_cnt", rxv_cnt - r0, 1);
    ss_n = 1'b1;
    wait_clk(8);

    // reset mid-byte
    load_tx(8'h55);
    ss_n = 1'b0;
    wait_clk(4);
    spi_bits(8'hAA, 3, mi);
    chk("mid_miso_bits", mi, 8'h40);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_miso", miso, 0);
    chk("mid_rst_miso_oe", miso_oe, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_tx_ready", bus.tx_ready, 1);
    chk("mid_rst_rx_data", bus.rx_data, 8'h00);
    chk("mid_rst_rx_valid", bus.rx_valid, 0);
    ss_n = 1'b1;
    sclk = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    chk("post_rst_busy", bus.busy, 0);

    // second load while buffer full is ignored
    r0 = rxv_cnt;
    load_tx(8'h11);
    load_tx(8'h22);
    chk("ign_tx_ready", bus.tx_ready, 0);
    ss_n = 1'b0;
    wait_clk(4);
    spi_bits(8'h00, 8, mi);
    chk("ign_miso_byte", mi, 8'h11);
    wait_clk(4);
    chk("ign_rx_cnt", rxv_cnt - r0, 1);
    chk("ign_rx_data", last_rx, 8'h00);
    ss_n = 1'b1;
    wait_clk(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
